// File: rtl/bcd_to_binary_converter.sv
// ---------------------------------------------------------------------------
// bcd_to_binary_converter : MSD-first Horner BCD-to-binary converter, one
// digit per enabled clock. Optional macro DIGIT_CHECK_EN adds invalid-digit
// detection. Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module bcd_to_binary_converter #(
  parameter int DIGITS = 5
) (
  input  logic                  trigger,
  input  logic                  reset,
  input  logic                  en,
  input  logic                  start,
  input  logic [4*DIGITS-1:0]   bcd_value,
  output logic [16:0]           binary_value,
  output logic                  busy,
  output logic                  done,
  output logic                  error
);

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    CONV = 1'b1
  } state_t;

  localparam logic [2:0] c_LAST = 3'(DIGITS - 1);

  state_t              r_state;
  state_t              w_next;
  logic [4*DIGITS-1:0] r_bcd;
  logic [16:0]         r_acc;
  logic [2:0]          r_idx;
  logic [16:0]         r_value;
  logic                r_busy;
  logic                r_done;
  logic [3:0]          w_digit;
  logic [16:0]         w_sum;
  logic                w_accept;
  logic                w_last;

  assign w_accept = en && (r_state == IDLE) && start;
  assign w_last   = (r_state == CONV) && (r_idx == 3'd0);
  assign w_digit  = r_bcd[{r_idx, 2'b00} +: 4];
  assign w_sum    = r_acc * 17'd10 + {13'd0, w_digit};

  always_ff @(posedge trigger or posedge reset) begin
    if (reset) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    if (en) begin
      case (r_state)
        IDLE:    if (start) w_next = CONV;
        CONV:    if (r_idx == 3'd0) w_next = IDLE;
        default: w_next = IDLE;
      endcase
    end
  end

`ifdef DIGIT_CHECK_EN
  logic r_bad;
  logic r_error;
  logic w_bad_any;

  // The sticky flag misses the digit consumed on the final edge, so fold it in.
  assign w_bad_any = r_bad || (w_digit > 4'd9);
  assign error     = r_error;

  always_ff @(posedge trigger or posedge reset) begin
    if (reset) begin
      r_bad   <= 1'b0;
      r_error <= 1'b0;
    end else if (en) begin
      if (w_accept) begin
        r_bad   <= 1'b0;
        r_error <= 1'b0;
      end else if (r_state == CONV) begin
        r_bad <= w_bad_any;
        if (w_last) r_error <= w_bad_any;
      end
    end
  end
`else
  assign error = 1'b0;
`endif

  always_ff @(posedge trigger or posedge reset) begin
    if (reset) begin
      r_bcd   <= '0;
      r_acc   <= '0;
      r_idx   <= '0;
      r_value <= '0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else if (en) begin
      r_done <= 1'b0;
      if (w_accept) begin
        r_bcd  <= bcd_value;
        r_acc  <= '0;
        r_idx  <= c_LAST;
        r_busy <= 1'b1;
      end else if (r_state == CONV) begin
        r_acc <= w_sum;
        if (w_last) begin
`ifdef DIGIT_CHECK_EN
          r_value <= w_bad_any ? 17'd0 : w_sum;
`else
          r_value <= w_sum;
`endif
          r_done <= 1'b1;
          r_busy <= 1'b0;
        end else begin
          r_idx <= r_idx - 3'd1;
        end
      end
    end
  end

  assign binary_value = r_value;
  assign busy         = r_busy;
  assign done         = r_done;

endmodule

`default_nettype wire

// File: doc/bcd_to_binary_converter.md
BCD_TO_BINARY_CONVERTER -- requirements
Module: bcd_to_binary_converter

Interface
REQ-001 The block SHALL have parameter DIGITS, default 5, giving the number of BCD digits converted (legal range 1..5).
REQ-002 The block SHALL have port trigger, input, 1 bit, the single clock; all state updates on its rising edge.
REQ-003 The block SHALL have port reset, input, 1 bit, an asynchronous active-high reset.
REQ-004 The block SHALL have port en, input, 1 bit, a clock enable; when low, all state is held.
REQ-005 The block SHALL have port start, input, 1 bit, a conversion request, sampled only in IDLE with en=1.
REQ-006 The block SHALL have port bcd_value, input, 4*DIGITS bits, the packed BCD digits, least-significant digit in [3:0].
REQ-007 The block SHALL have port binary_value, output, 17 bits, the unsigned binary result, registered and held until the next completion.
REQ-008 The block SHALL have port busy, output, 1 bit, which is high while a conversion is in progress.
REQ-009 The block SHALL have port done, output, 1 bit, a single-cycle completion pulse.
REQ-010 The block SHALL have port error, output, 1 bit, an invalid-digit flag, valid while done=1 (present only per REQ-024).

Function
REQ-011 The FSM SHALL have states IDLE and CONV; reset state is IDLE.
REQ-012 IDLE: at an edge with en=1 and start=1, the block SHALL latch bcd_value into an internal register, clear the accumulator, set the digit index to DIGITS-1, set busy=1 and go to CONV.
REQ-013 CONV: at each edge with en=1, the block SHALL compute acc <= acc*10 + digit[index] (17-bit, modulo 2^17) and decrement the index; this is the MSD-first Horner scheme.
REQ-014 At the CONV edge processing index 0, the block SHALL write the final sum to binary_value, pulse done=1 for exactly the next cycle, clear busy and return to IDLE.
REQ-015 Latency: if start is accepted at edge N with en held high, done and the new binary_value SHALL be visible after edge N+DIGITS.
REQ-016 start SHALL be ignored while busy=1; bcd_value changes after acceptance SHALL NOT affect the result.
REQ-017 start=1 in the cycle where done=1 SHALL be accepted, because the FSM is already in IDLE, giving back-to-back conversions every DIGITS cycles.
REQ-018 en=0 SHALL freeze the state, accumulator, index and outputs; a done pulse that is pending lasts until the first edge with en=1.
REQ-019 Maximum valid input 99999 SHALL yield 0x1869F, which fits in 17 bits, so valid inputs never overflow.
REQ-020 done SHALL be 0 in every cycle other than the one cycle defined in REQ-014.

Reset
REQ-021 Asserting reset SHALL immediately force IDLE and set binary_value=0, busy=0, done=0, error=0, and clear the accumulator, index and latched input, regardless of en.
REQ-022 Reset asserted mid-conversion SHALL abort the conversion with no done pulse; after release, the block SHALL accept a new start.

Configuration
REQ-023 Macro DIGIT_CHECK_EN SHALL control invalid-digit detection.
REQ-024 With DIGIT_CHECK_EN defined, the following SHALL apply:
- any latched digit >9 sets a sticky internal flag during CONV;
- at completion, error=1 for the done cycle and binary_value=0;
- otherwise error=0;
- error SHALL clear when the next start is accepted.
REQ-025 Without DIGIT_CHECK_EN, the following SHALL apply:
- the error port SHALL be tied to 0;
- digits >9 SHALL be used arithmetically as their 4-bit value, with the result truncated modulo 2^17.

Verification
REQ-026 bcd_value=0x12345, start pulse, en=1 -> after 5 edges done=1 for 1 cycle, binary_value=0x03039, busy high for 5 cycles.
REQ-027 bcd_value=0x99999 -> binary_value=0x1869F; then start in the done cycle with 0x00000 -> 5 edges later binary_value=0, done=1.
REQ-028 start 0x00042, en low for 3 cycles after the second CONV edge -> done delayed by exactly 3 cycles, binary_value=42.
REQ-029 start 0x54321, reset asserted after 2 CONV edges -> all outputs 0 immediately, no done pulse; a new start of 0x00007 then gives 7.
REQ-030 With DIGIT_CHECK_EN: 0x1A000 -> done=1, error=1, binary_value=0; the following 0x00010 gives error=0 and binary_value=10.
REQ-031 start re-asserted while busy with a different bcd_value -> ignored; the result reflects the first value only.
